wb_slave_mem: RTL

- Synthesizable Wishbone classic slave memory. Sits directly downstream of the AHB-to-WB bridge and consumes its WB master cycles.
- Used as the bridge's target in block- and system-level tests, and as a generic on-chip scratch RAM.
- Provides byte-enabled word storage, programmable wait states, and error responses for misaligned and out-of-range accesses.

---
 rtl/wb_slave_mem_if.sv | 35 +++
 rtl/wb_slave_mem.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle between a master (bridge or bench) and wb_slave_mem.
// The wb_rty_o signal exists only when WB_SLAVE_MEM_RTY_EN is defined.
interface wb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic                    wb_ack_o;
  logic                    wb_err_o;
`ifdef WB_SLAVE_MEM_RTY_EN
  logic                    wb_rty_o;
`endif

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
`ifdef WB_SLAVE_MEM_RTY_EN
    input  wb_rty_o,
`endif
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
`ifdef WB_SLAVE_MEM_RTY_EN
    output wb_rty_o,
`endif
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave RAM with byte lanes, programmable wait states and error responses.
// Define WB_SLAVE_MEM_RTY_EN to add wb_rty_o and per-bus-cycle retry of the first requests.
module wb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
`ifdef WB_SLAVE_MEM_RTY_EN
  ,
  parameter int unsigned RETRY_COUNT = 1
`endif
) (
  input logic           hclk,
  input logic           hresetn,
  wb_slave_mem_if.slave wb
);
  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = ADDR_WIDTH - 2;
  localparam int unsigned MemAw    = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [NumLanes-1:0]   sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  bad_q, bad_d;
  logic                  rty_q, rty_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  req;
  logic [ADDR_WIDTH-1:0] cur_adr;
  logic                  cur_we;
  logic [NumLanes-1:0]   cur_sel;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic                  cur_rty;
  logic [IdxW-1:0]       word_idx;
  logic [MemAw-1:0]      mem_idx;
  logic                  cur_bad;
  logic                  retry_now;
  logic                  enter_resp;
  logic                  mem_we;

  assign req = wb.wb_cyc_i & wb.wb_stb_i;

  // On the request edge the live bus is used; afterwards the latched copy.
  always_comb begin
    if (state_q == StIdle) begin
      cur_adr = wb.wb_adr_i;
      cur_we  = wb.wb_we_i;
      cur_sel = wb.wb_sel_i;
      cur_dat = wb.wb_dat_i;
      cur_rty = retry_now;
    end else begin
      cur_adr = adr_q;
      cur_we  = we_q;
      cur_sel = sel_q;
      cur_dat = dat_q;
      cur_rty = rty_q;
    end
  end

  assign word_idx = cur_adr[ADDR_WIDTH-1:2];
  assign mem_idx  = cur_adr[MemAw+1:2];
  assign cur_bad  = (|cur_adr[1:0]) | (32'(word_idx) >= DEPTH);

`ifdef WB_SLAVE_MEM_RTY_EN
  logic [15:0] rty_cnt_q, rty_cnt_d;

  assign retry_now = 32'(rty_cnt_q) < RETRY_COUNT;

  // Only retried requests advance the count, so it saturates at RETRY_COUNT.
  always_comb begin
    rty_cnt_d = rty_cnt_q;
    if (!wb.wb_cyc_i) begin
      rty_cnt_d = '0;
    end else if (state_q == StIdle && req && retry_now) begin
      rty_cnt_d = rty_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rty_cnt_q <= '0;
    end else begin
      rty_cnt_q <= rty_cnt_d;
    end
  end
`else
  assign retry_now = 1'b0;
`endif

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_q != StResp) && (state_d == StResp);

  always_comb begin
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    bad_d   = bad_q;
    rty_d   = rty_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    if (state_q == StIdle && req) begin
      adr_d = wb.wb_adr_i;
      we_d  = wb.wb_we_i;
      sel_d = wb.wb_sel_i;
      dat_d = wb.wb_dat_i;
      bad_d = cur_bad;
      rty_d = retry_now;
    end
    if (enter_resp && !cur_bad && !cur_rty) begin
      if (cur_we) begin
        mem_we = 1'b1;
      end else begin
        rdata_d = mem_q[mem_idx];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      bad_q   <= 1'b0;
      rty_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      bad_q   <= bad_d;
      rty_q   <= rty_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; a zero-wait request held during reset must not write.
  always_ff @(posedge hclk) begin
    if (hresetn && mem_we) begin
      for (int unsigned b = 0; b < NumLanes; b++) begin
        if (cur_sel[b]) begin
          mem_q[mem_idx][b*8 +: 8] <= cur_dat[b*8 +: 8];
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    wb.wb_dat_o = rdata_q;
    wb.wb_ack_o = (state_q == StResp) && !bad_q && !rty_q;
    wb.wb_err_o = (state_q == StResp) && bad_q && !rty_q;
`ifdef WB_SLAVE_MEM_RTY_EN
    wb.wb_rty_o = (state_q == StResp) && rty_q;
`endif
  end
endmodule
